// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-and-add multiplier (controller + datapath).
//
// Contents:
//   DEFAULT_WIDTH        default operand width in bits
//   SEL_HOLD/STEP/IDLE/DONE  encoding of the controller's 2-bit sel strobe
//   is_step / is_done    small decode helpers used by the datapath
// -----------------------------------------------------------------------------
package mult_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_STEP = 2'b01;
   localparam logic [1:0] SEL_IDLE = 2'b10;
   localparam logic [1:0] SEL_DONE = 2'b11;

   function automatic logic is_step(input logic [1:0] sel);
      return sel == SEL_STEP;
   endfunction

   function automatic logic is_done(input logic [1:0] sel);
      return sel == SEL_DONE;
   endfunction

endpackage : mult_pkg

// File: rtl/mult_shiftreg.sv
// -----------------------------------------------------------------------------
// mult_shiftreg
// The {C,A,Q} register of the shift-and-add multiplier: C is the carry bit,
// A the accumulator (upper product half) and Q the multiplier, which fills
// with the lower product half as it is shifted out.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low reset
//   load   in   load Q from b_in, clear A and C (highest priority)
//   sel    in   controller state strobe (hold/step/idle/done)
//   add    in   in a step cycle, add M into A
//   shift  in   shift {C,A,Q} right one bit
//   inbit  in   new value of C after a shift
//   m      in   multiplicand from the M register
//   b_in   in   multiplier operand
//   a      out  accumulator A
//   q      out  multiplier/low-product register Q
// -----------------------------------------------------------------------------
module mult_shiftreg
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [1:0]       sel,
   input  logic             add,
   input  logic             shift,
   input  logic             inbit,
   input  logic [WIDTH-1:0] m,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             c_q, c_d;
   logic [WIDTH:0]   sum;

   always_comb begin
      // One extra bit so the addition can never overflow.
      sum = {1'b0, a_q} + (add ? {1'b0, m} : '0);

      // NOTE: every next-state signal gets its hold value first, so no path
      // through the if-chain leaves it unassigned and no latch is inferred.
      a_d = a_q;
      q_d = q_q;
      c_d = c_q;

      if (load) begin
         a_d = '0;
         q_d = b_in;
         c_d = 1'b0;
      end else if (is_step(sel)) begin
         if (shift) begin
            // Add and shift in one cycle: the sum's carry lands in A's MSB,
            // the sum's LSB moves into Q's MSB and the old Q[0] is dropped.
            a_d = sum[WIDTH:1];
            q_d = {sum[0], q_q[WIDTH-1:1]};
            c_d = inbit;
         end else begin
            {c_d, a_d} = sum;
         end
      end else if (!is_done(sel) && shift) begin
         // Plain shift outside a step; the done state ignores shift entirely.
         a_d = {c_q, a_q[WIDTH-1:1]};
         q_d = {a_q[0], q_q[WIDTH-1:1]};
         c_d = inbit;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q <= '0;
         q_q <= '0;
         c_q <= 1'b0;
      end else begin
         a_q <= a_d;
         q_q <= q_d;
         c_q <= c_d;
      end
   end

   assign a = a_q;
   assign q = q_q;

endmodule : mult_shiftreg

// File: rtl/mult_datapath.sv
// -----------------------------------------------------------------------------
// mult_datapath
// Shift-and-add multiplier datapath driven by the controller's strobes.
// Holds the multiplicand M, instantiates the {C,A,Q} shift register, returns
// Q[0] to the controller and captures the finished product with a one-cycle
// valid pulse on the rising edge of the controller's valid strobe.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   a_in           in   multiplicand, sampled on load
//   b_in           in   multiplier, sampled on load
//   load           in   load operands, clear A and C
//   sel            in   00 hold, 01 step, 10 idle, 11 done
//   add            in   in a step, add M into A
//   shift          in   shift {C,A,Q} right one bit
//   inbit          in   new C after a shift
//   valid          in   product complete
//   sign           out  Q[0], combinational, to the controller
//   product        out  registered {A,Q}
//   product_valid  out  one-cycle pulse when product is updated
// -----------------------------------------------------------------------------
module mult_datapath
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   input  logic               load,
   input  logic [1:0]         sel,
   input  logic               add,
   input  logic               shift,
   input  logic               inbit,
   input  logic               valid,
   output logic               sign,
   output logic [2*WIDTH-1:0] product,
   output logic               product_valid
);

   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   q;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               product_valid_q, product_valid_d;
   logic               valid_prev_q, valid_prev_d;
   logic               capture;

   mult_shiftreg #(
      .WIDTH (WIDTH)
   ) u_shiftreg (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .sel   (sel),
      .add   (add),
      .shift (shift),
      .inbit (inbit),
      .m     (m_q),
      .b_in  (b_in),
      .a     (a),
      .q     (q)
   );

   // Capture uses {A,Q} as it stands before this edge.
   assign capture = is_done(sel) && valid;

   always_comb begin
      m_d             = load ? a_in : m_q;
      product_d       = capture ? {a, q} : product_q;
      // Pulse only on a rising valid so a held valid yields a single pulse.
      product_valid_d = capture && !valid_prev_q;
      // Tracks valid in every state, not just done.
      valid_prev_d    = valid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q             <= '0;
         product_q       <= '0;
         product_valid_q <= 1'b0;
         valid_prev_q    <= 1'b0;
      end else begin
         m_q             <= m_d;
         product_q       <= product_d;
         product_valid_q <= product_valid_d;
         valid_prev_q    <= valid_prev_d;
      end
   end

   assign sign          = q[0];
   assign product       = product_q;
   assign product_valid = product_valid_q;

endmodule : mult_datapath

// File: tb/tb_mult_datapath.sv
// -----------------------------------------------------------------------------
// tb_mult_datapath
// Self-checking bench for mult_datapath (WIDTH=8). A behavioural model holds
// {C,A,Q} as one integer and updates it with plain arithmetic; a compare
// process checks sign/product/product_valid against it on every falling edge.
// Directed runs pin the model with hand-computed products and sign sequences.
// -----------------------------------------------------------------------------
module tb_mult_datapath;

   localparam int W = 8;
   localparam longint unsigned HALF = 64'd1 << W;
   localparam longint unsigned FULL = 64'd1 << (2 * W);

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   a_in, b_in;
   logic           load, add, shift, inbit, valid;
   logic [1:0]     sel;
   logic           sign;
   logic [2*W-1:0] product;
   logic           product_valid;

   int checks = 0;
   int errors = 0;

   // Behavioural model: caq_m = C*2^(2W) + A*2^W + Q
   longint unsigned m_m, caq_m, prod_m;
   logic            pv_m, prev_m;

   mult_datapath #(.WIDTH(W)) dut (
      .clk           (clk),
      .reset         (reset),
      .a_in          (a_in),
      .b_in          (b_in),
      .load          (load),
      .sel           (sel),
      .add           (add),
      .shift         (shift),
      .inbit         (inbit),
      .valid         (valid),
      .sign          (sign),
      .product       (product),
      .product_valid (product_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_m    = 0;
      caq_m  = 0;
      prod_m = 0;
      pv_m   = 1'b0;
      prev_m = 1'b0;
   endtask

   // Applies one clock edge of the datapath rules to the model.
   task automatic model_update();
      longint unsigned qv, av, s;
      qv = caq_m % HALF;
      av = (caq_m / HALF) % HALF;
      if (sel == 2'b11 && valid) begin
         prod_m = caq_m % FULL;
         pv_m   = !prev_m;
      end else begin
         pv_m = 1'b0;
      end
      prev_m = valid;
      if (load) begin
         m_m   = a_in;
         caq_m = b_in;
      end else if (sel == 2'b01) begin
         s = av + (add ? m_m : 0);
         if (shift) caq_m = inbit * FULL + ((s * HALF + qv) / 2);
         else       caq_m = s * HALF + qv;
      end else if (sel != 2'b11 && shift) begin
         caq_m = inbit * FULL + (caq_m / 2);
      end
   endtask

   // Drive one cycle of controller strobes; returns at the following negedge.
   task automatic drive(input logic ld, input logic [1:0] s, input logic ad,
                        input logic sh, input logic ib, input logic v);
      load  = ld;
      sel   = s;
      add   = ad;
      shift = sh;
      inbit = ib;
      valid = v;
      @(posedge clk);
      if (reset) model_update();
      else       model_reset();
      @(negedge clk);
   endtask

   task automatic drive_random();
      a_in = W'($urandom);
      b_in = W'($urandom);
      drive(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
   endtask

   // Full multiply as the controller would sequence it.
   task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic noisy_load,
                           output logic [2*W-1:0] prod, output int pulses,
                           output logic [W-1:0] signs);
      a_in = a;
      b_in = b;
      if (noisy_load) drive(1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
      else            drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("load_sign", sign, b[0]);
      for (int i = 0; i < W; i++) begin
         signs[i] = sign;
         drive(1'b0, 2'b01, sign, 1'b1, 1'b0, 1'b0);
      end
      pulses = 0;
      drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      pulses += int'(product_valid);
      prod = product;
      drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      pulses += int'(product_valid);
      drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Compare process: DUT outputs against the model every cycle.
   initial begin
      forever begin
         @(negedge clk);
         check("sign", sign, caq_m % 2);
         check("product", product, prod_m);
         check("product_valid", product_valid, pv_m);
      end
   end

   initial begin
      logic [2*W-1:0] prod;
      logic [W-1:0]   signs;
      logic [W-1:0]   ra, rb;
      int             pulses;

      reset = 1'b0;
      a_in = '0; b_in = '0; load = 0; sel = 2'b00; add = 0; shift = 0; inbit = 0; valid = 0;
      model_reset();

      // Reset held with random inputs toggling
      @(negedge clk);
      for (int i = 0; i < 6; i++) drive_random();
      check("rst_product", product, 0);
      check("rst_pvalid", product_valid, 0);
      check("rst_sign", sign, 0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rel_product", product, 0);
      check("rel_pvalid", product_valid, 0);
      check("rel_sign", sign, 0);

      // Basic multiply 13*11
      run_mult(8'd13, 8'd11, 1'b0, prod, pulses, signs);
      check("mul13x11", prod, 16'h008F);
      check("mul13x11_pulses", pulses, 1);
      check("mul13x11_signs", signs, 8'b0000_1011);

      // Load priority: strobes asserted during load must not take effect
      run_mult(8'd37, 8'd91, 1'b1, prod, pulses, signs);
      check("loadprio_prod", prod, 37 * 91);
      check("loadprio_pulses", pulses, 1);

      // Max operands
      run_mult(8'd255, 8'd255, 1'b0, prod, pulses, signs);
      check("mul255x255", prod, 16'hFE01);
      check("mul255x255_signs", signs, 8'hFF);

      // Held valid: one pulse, then a second after valid drops
      drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      check("held_v1", product_valid, 1);
      drive(1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
      check("held_v2", product_valid, 0);
      drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      check("held_v3", product_valid, 0);
      drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      check("repulse_v", product_valid, 1);
      check("repulse_prod", product, 16'hFE01);
      drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

      // valid outside done: no capture, no pulse
      drive(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
      check("valid_notdone", product_valid, 0);
      drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);

      // Mid-operation reset after 4 steps of 200*100
      a_in = 8'd200;
      b_in = 8'd100;
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 2'b01, sign, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b0;
      model_reset();
      #1;
      check("async_product", product, 0);
      check("async_pvalid", product_valid, 0);
      check("async_sign", sign, 0);
      @(negedge clk);
      drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
      check("inreset_pvalid", product_valid, 0);
      reset = 1'b1;
      run_mult(8'd7, 8'd6, 1'b0, prod, pulses, signs);
      check("mul7x6", prod, 16'd42);
      check("mul7x6_pulses", pulses, 1);

      // Random operands through the normal sequence
      for (int n = 0; n < 20; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_mult(ra, rb, 1'($urandom), prod, pulses, signs);
         check("rand_prod", prod, 64'(ra) * 64'(rb));
         check("rand_pulses", pulses, 1);
         check("rand_signs", signs, rb);
      end

      // Random strobe soup, checked cycle by cycle against the model
      for (int i = 0; i < 400; i++) drive_random();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mult_datapath
